// File: rtl/vga_pkg.sv
// Shared definitions for the VGA scan-out path: default geometry, pixel type
// and the VRAM arbiter state encoding.
package vga_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned PIX_DW_DEF   = 12;

    // One RGB444 pixel.
    typedef logic [PIX_DW_DEF-1:0] pixel_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StRun  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/vram_prefetch_fifo.sv
// First-word-fall-through prefetch FIFO: the head entry is always visible on
// rdata_o, and a pop simply advances past it. flush_i empties the FIFO and
// takes priority over a push or pop in the same cycle.
module vram_prefetch_fifo #(
    parameter int unsigned DW    = 12,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o
);

    logic [DW-1:0] storage_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointer and occupancy update; pointers wrap naturally (DEPTH is 2^PW).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) storage_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = storage_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/vram_scan_arbiter.sv
// Single-port VRAM arbiter between display prefetch (priority) and a game-logic
// writer. Optional feature: define VRAM_WR_SLOT_EN to let a writer that has
// waited 16 cycles steal one display slot in RUN when the FIFO holds >= 2.
module vram_scan_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned AW         = 19,
    parameter int unsigned DW         = 12,
    parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_start,
    input  logic          pix_req,
    output logic [DW-1:0] pix_data,
    output logic          underflow,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [AW-1:0] PIX_TOTAL = AW'(H_ACTIVE * V_ACTIVE);

    arb_state_e    state_q, state_d;
    logic [AW-1:0] fetch_addr_q, fetch_addr_d;
    logic          inflight_q, inflight_d;
    logic [1:0]    discard_q, discard_d;
    logic          underflow_q, underflow_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic [DW-1:0] fifo_head;
    logic          fill_room, rd_issue, wr_grant, force_wr, push, pop;

`ifdef VRAM_WR_SLOT_EN
    logic [3:0] wait_q, wait_d;
`endif

    // Arbitration: display read unless the starved writer is forced through.
    always_comb begin
        fill_room = ({1'b0, fifo_count} + {{CW{1'b0}}, inflight_q}) < (CW + 1)'(FIFO_DEPTH);
`ifdef VRAM_WR_SLOT_EN
        force_wr = wr_valid && (state_q == StRun) && (wait_q == 4'd15) &&
                   (fifo_count >= CW'(2));
`else
        force_wr = 1'b0;
`endif
        rd_issue = (state_q != StIdle) && (fetch_addr_q < PIX_TOTAL) && fill_room && !force_wr;
        // Gated by rst_n so every output reads 0 while reset is held.
        wr_grant = rst_n && wr_valid && !rd_issue &&
                   ((state_q == StRun) || (state_q == StIdle));
    end

    // VRAM port and writer handshake.
    always_comb begin
        mem_en    = rd_issue || wr_grant;
        mem_we    = wr_grant;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rd_issue) begin
            mem_addr = fetch_addr_q;
        end else if (wr_grant) begin
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end
        wr_ready = wr_grant;
    end

    // Read return, pixel consume and flush bookkeeping.
    always_comb begin
        // A read issued in the frame_start cycle belongs to the old frame.
        push         = inflight_q && (discard_q == 2'd0) && !frame_start;
        pop          = pix_req && !fifo_empty && !frame_start;
        inflight_d   = rd_issue;
        fetch_addr_d = fetch_addr_q;
        discard_d    = discard_q;
        underflow_d  = underflow_q;
        if (frame_start) begin
            fetch_addr_d = '0;
            // Any data returning now is dropped by the flush itself.
            discard_d    = {1'b0, rd_issue};
            underflow_d  = 1'b0;
        end else begin
            if (rd_issue) fetch_addr_d = fetch_addr_q + AW'(1);
            if (inflight_q && (discard_q != 2'd0)) discard_d = discard_q - 2'd1;
            if (pix_req && fifo_empty) underflow_d = 1'b1;
        end
    end

    // State machine next-state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (frame_start) state_d = StFill;
            StFill: begin
                if (frame_start) state_d = StFill;
                else if (fifo_count == CW'(FIFO_DEPTH)) state_d = StRun;
            end
            StRun:  if (frame_start) state_d = StFill;
            default: state_d = StIdle;
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            fetch_addr_q <= '0;
            inflight_q   <= 1'b0;
            discard_q    <= 2'd0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            inflight_q   <= inflight_d;
            discard_q    <= discard_d;
            underflow_q  <= underflow_d;
        end
    end

`ifdef VRAM_WR_SLOT_EN
    // Writer starvation counter: consecutive cycles with wr_valid and no grant.
    always_comb begin
        wait_d = wait_q;
        if (!wr_valid || wr_grant) wait_d = 4'd0;
        else if (wait_q != 4'd15) wait_d = wait_q + 4'd1;
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_q <= 4'd0;
        else        wait_q <= wait_d;
    end
`endif

    assign underflow = underflow_q;
    assign pix_data  = pop ? fifo_head : '0;

    vram_prefetch_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (frame_start),
        .push_i  (push),
        .wdata_i (mem_rdata),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Directed bench for vram_scan_arbiter with a behavioural single-port VRAM
// whose word n is preloaded with n[11:0].
module tb_vram_scan_arbiter;
    import vga_pkg::*;

    localparam int unsigned AW   = 19;
    localparam int unsigned DW   = 12;
    localparam int unsigned NPIX = 640 * 480;

    logic          clk;
    logic          rst_n;
    logic          frame_start;
    logic          pix_req;
    logic [DW-1:0] pix_data;
    logic          underflow;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    pixel_t vram [NPIX];
    pixel_t rdata_q;

    int tests;
    int fails;

    vram_scan_arbiter #(
        .AW         (AW),
        .DW         (DW),
        .H_ACTIVE   (640),
        .V_ACTIVE   (480),
        .FIFO_DEPTH (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pix_req     (pix_req),
        .pix_data    (pix_data),
        .underflow   (underflow),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM, read data valid one cycle after the read.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                if (int'(mem_addr) < NPIX) vram[mem_addr] <= mem_wdata;
            end else begin
                rdata_q <= vram[mem_addr];
            end
        end
    end
    assign mem_rdata = rdata_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_pix;
        logic        exp_wr;
        tests       = 0;
        fails       = 0;
        clk         = 1'b0;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        pix_req     = 1'b0;
        wr_valid    = 1'b1;
        wr_addr     = AW'(5);
        wr_data     = 12'h123;
        rdata_q     = '0;
        for (int n = 0; n < int'(NPIX); n++) vram[n] = DW'(n);

        // Reset: every output low even with wr_valid asserted.
        @(negedge clk);
        #1;
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_wr_ready", 32'(wr_ready), 0);
        check("rst_underflow", 32'(underflow), 0);
        check("rst_pix_data", 32'(pix_data), 0);
        check("rst_state", 32'(dut.state_q), 32'(StIdle));

        @(negedge clk);
        wr_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        #1;
        check("idle_no_access", 32'(mem_en), 0);

        // Frame start from IDLE: no read in the pulse cycle, then 0..7.
        @(negedge clk);
        frame_start = 1'b1;
        #1;
        check("fs_idle_no_read", 32'(mem_en), 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            frame_start = 1'b0;
            #1;
            check("fill_rd_en", 32'(mem_en && !mem_we), 1);
            check("fill_rd_addr", 32'(mem_addr), 32'(k));
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("fill_done_idle_bus", 32'(mem_en), 0);
        end
        check("fill_state_run", 32'(dut.state_q), 32'(StRun));
        check("fill_count_full", 32'(dut.fifo_count), 8);

        // Writer gets the free slot while the FIFO is full.
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = AW'(12'h100);
        wr_data  = 12'hABC;
        #1;
        check("wr_ready", 32'(wr_ready), 1);
        check("wr_mem_en", 32'(mem_en), 1);
        check("wr_mem_we", 32'(mem_we), 1);
        check("wr_mem_addr", 32'(mem_addr), 32'h100);
        check("wr_mem_wdata", 32'(mem_wdata), 32'hABC);
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        check("wr_ready_drop", 32'(wr_ready), 0);

        // One full line of consumption; a writer waits from the third pixel on.
        for (int i = 0; i < 640; i++) begin
            @(negedge clk);
            pix_req = 1'b1;
            if (i == 2) begin
                wr_valid = 1'b1;
                wr_addr  = AW'(12'h300);
                wr_data  = 12'h555;
            end
`ifdef VRAM_WR_SLOT_EN
            if (i == 18) wr_valid = 1'b0;
            exp_wr = (i == 17);
`else
            exp_wr = 1'b0;
`endif
            exp_pix = (i == 256) ? 32'hABC : 32'(i);
            #1;
            check("line_pix_data", 32'(pix_data), exp_pix);
            check("line_wr_ready", 32'(wr_ready), 32'(exp_wr));
            check("line_mem_en", 32'(mem_en), 32'(i != 0));
            check("line_count_nonzero", 32'(dut.fifo_count != 0), 1);
        end
        @(negedge clk);
        pix_req  = 1'b0;
        wr_valid = 1'b0;
        #1;
        check("line_no_underflow", 32'(underflow), 0);
        repeat (12) @(negedge clk);
        #1;
        check("refill_count_full", 32'(dut.fifo_count), 8);

        // Pop pixel 640, then frame_start while the next read is issued.
        @(negedge clk);
        pix_req = 1'b1;
        #1;
        check("pix_640", 32'(pix_data), 32'h280);
        @(negedge clk);
        pix_req     = 1'b0;
        frame_start = 1'b1;
        #1;
        check("fs_read_issued", 32'(mem_en && !mem_we), 1);
        check("fs_read_addr", 32'(mem_addr), 648);
        @(negedge clk);
        frame_start = 1'b0;
        #1;
        check("fs_discard_pending", 32'(dut.discard_q), 1);
        check("fs_restart_addr", 32'(mem_addr), 0);
        check("fs_restart_en", 32'(mem_en), 1);
        repeat (12) @(negedge clk);
        #1;
        check("fs_refill_run", 32'(dut.state_q), 32'(StRun));
        check("fs_discard_clear", 32'(dut.discard_q), 0);
        check("fs_refill_count", 32'(dut.fifo_count), 8);
        @(negedge clk);
        pix_req = 1'b1;
        #1;
        check("fs_first_pix", 32'(pix_data), 0);
        @(negedge clk);
        #1;
        check("fs_second_pix", 32'(pix_data), 1);

        // frame_start with pix_req: flush wins; next pix_req underflows.
        @(negedge clk);
        frame_start = 1'b1;
        pix_req     = 1'b1;
        #1;
        check("fs_pop_ignored", 32'(pix_data), 0);
        @(negedge clk);
        frame_start = 1'b0;
        #1;
        check("fs_no_underflow", 32'(underflow), 0);
        check("empty_pix_zero", 32'(pix_data), 0);
        @(negedge clk);
        pix_req = 1'b0;
        #1;
        check("underflow_set", 32'(underflow), 1);
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        #1;
        check("underflow_cleared", 32'(underflow), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
